// File: rtl/clock_tap_controller.sv
// Closed-loop phi0 delay-line tap controller: measures the phi0->phi2 phase,
// averages the samples and steps the tap toward TARGET, with manual override.
module clock_tap_controller #(
  parameter int TAP_W      = 9,
  parameter int TAP_INIT   = 50,
  parameter int TAP_MIN    = 0,
  parameter int TAP_MAX    = 499,
  parameter int TARGET     = 0,
  parameter int DEADBAND   = 2,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE     = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic               eclk,
  input  logic               ereset,
  input  logic               phi0,
  input  logic               phi2,
  input  logic               enable,
  input  logic               btn_inc,
  input  logic               btn_dec,
  output logic [TAP_W-1:0]   tap,
  output logic signed [15:0] diff,
  output logic               diff_valid,
  output logic signed [15:0] avg,
  output logic               locked,
  output logic               at_limit
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam logic signed [16:0] DB_POS = 17'(DEADBAND);
  localparam logic signed [16:0] DB_NEG = -17'(DEADBAND);
  localparam logic signed [16:0] TGT    = 17'(TARGET);
  localparam logic [AVG_LOG2-1:0] LAST_SAMPLE = '1;

  typedef enum logic [1:0] {IDLE, WAIT2, WAIT0} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        meas_abort;

  logic phi0_d, phi2_d, inc_d, dec_d;
  logic phi0_rise, phi2_rise, inc_rise, dec_rise;

  logic signed [ACC_W-1:0] acc, acc_next, acc_shift;
  logic [AVG_LOG2-1:0]     sample_cnt;
  logic [7:0]              settle_cnt;
  logic [7:0]              lock_cnt;
  logic                    avg_valid;

  logic signed [16:0] err;
  logic out_band, auto_up, auto_dn, manual_act;
  logic step_up, step_dn, can_up, can_dn, step_ok, step_blk;

  // History regs come out of reset high so an input already high is not an edge.
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      phi0_d    <= 1'b1;
      phi2_d    <= 1'b1;
      inc_d     <= 1'b1;
      dec_d     <= 1'b1;
      phi0_rise <= 1'b0;
      phi2_rise <= 1'b0;
      inc_rise  <= 1'b0;
      dec_rise  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the old value of its neighbours.
      phi0_d    <= phi0;
      phi2_d    <= phi2;
      inc_d     <= btn_inc;
      dec_d     <= btn_dec;
      phi0_rise <= phi0 & ~phi0_d;
      phi2_rise <= phi2 & ~phi2_d;
      inc_rise  <= btn_inc & ~inc_d;
      dec_rise  <= btn_dec & ~dec_d;
    end
  end

  // Phase measurement: ticks between the phi0 and phi2 edge pulses.
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state      <= IDLE;
      cnt        <= '0;
      diff       <= '0;
      diff_valid <= 1'b0;
      meas_abort <= 1'b0;
    end else begin
      diff_valid <= 1'b0;
      meas_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (phi0_rise && phi2_rise) begin
            diff       <= '0;
            diff_valid <= 1'b1;
          end else if (phi0_rise) begin
            state <= WAIT2;
            cnt   <= 16'd1;
          end else if (phi2_rise) begin
            state <= WAIT0;
            cnt   <= 16'd1;
          end
        end
        WAIT2, WAIT0: begin
          logic closing, restart;
          closing = (state == WAIT2) ? phi2_rise : phi0_rise;
          restart = (state == WAIT2) ? phi0_rise : phi2_rise;
          if (closing) begin
            diff       <= (state == WAIT2) ? cnt : -cnt;
            diff_valid <= 1'b1;
            cnt        <= 16'd1;
            if (!restart) state <= IDLE;
          end else if (restart) begin
            cnt <= 16'd1;
          end else if (cnt >= 16'(TIMEOUT)) begin
            state      <= IDLE;
            meas_abort <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_next  = acc + $signed({{AVG_LOG2{diff[15]}}, diff});
  assign acc_shift = acc_next >>> AVG_LOG2;

  assign err      = $signed({avg[15], avg}) - TGT;
  assign out_band = (err > DB_POS) || (err < DB_NEG);
  assign auto_up  = avg_valid && enable && (err < DB_NEG);
  assign auto_dn  = avg_valid && enable && (err > DB_POS);

  // Any button edge overrides this cycle's automatic request; both buttons cancel.
  assign manual_act = inc_rise | dec_rise;
  assign step_up    = manual_act ? (inc_rise & ~dec_rise) : auto_up;
  assign step_dn    = manual_act ? (dec_rise & ~inc_rise) : auto_dn;
  assign can_up     = tap < TAP_W'(TAP_MAX);
  assign can_dn     = tap > TAP_W'(TAP_MIN);
  assign step_ok    = (step_up & can_up) | (step_dn & can_dn);
  assign step_blk   = (step_up & ~can_up) | (step_dn & ~can_dn);

  // Averaging, lock tracking and tap stepping share acc/lock state, so one block owns them.
  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      tap        <= TAP_W'(TAP_INIT);
      avg        <= '0;
      avg_valid  <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
      settle_cnt <= 8'(SETTLE);
      lock_cnt   <= '0;
      locked     <= 1'b0;
      at_limit   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;

      if (diff_valid) begin
        if (settle_cnt != 8'd0) begin
          settle_cnt <= settle_cnt - 8'd1;
        end else if (sample_cnt == LAST_SAMPLE) begin
          avg        <= acc_shift[15:0];
          avg_valid  <= 1'b1;
          acc        <= '0;
          sample_cnt <= '0;
        end else begin
          acc        <= acc_next;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end

      if (meas_abort) begin
        acc        <= '0;
        sample_cnt <= '0;
      end

      if (avg_valid) begin
        if (out_band) begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end else begin
          if (lock_cnt != 8'(LOCK_COUNT)) lock_cnt <= lock_cnt + 8'd1;
          if (lock_cnt >= 8'(LOCK_COUNT - 1)) locked <= 1'b1;
        end
      end

      // A successful step restarts the measurement window and drops lock.
      if (step_ok) begin
        tap        <= step_up ? tap + 1'b1 : tap - 1'b1;
        at_limit   <= 1'b0;
        settle_cnt <= 8'(SETTLE);
        acc        <= '0;
        sample_cnt <= '0;
        lock_cnt   <= '0;
        locked     <= 1'b0;
      end else if (step_blk) begin
        at_limit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_tap_controller.sv
// Directed bench for clock_tap_controller: phase measurement, averaging,
// closed-loop convergence, limits, manual override, timeout and async reset.
module tb_clock_tap_controller;

  logic        eclk = 1'b0;
  logic        ereset;
  logic        phi0, phi2, enable, btn_inc, btn_dec;
  logic [8:0]  tap;
  logic [15:0] diff;
  logic        diff_valid;
  logic [15:0] avg;
  logic        locked, at_limit;

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  int dv_snap;

  clock_tap_controller dut (
    .eclk       (eclk),
    .ereset     (ereset),
    .phi0       (phi0),
    .phi2       (phi2),
    .enable     (enable),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .tap        (tap),
    .diff       (diff),
    .diff_valid (diff_valid),
    .avg        (avg),
    .locked     (locked),
    .at_limit   (at_limit)
  );

  always #5 eclk = ~eclk;

  always @(posedge eclk) if (diff_valid === 1'b1) dv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge eclk);
  endtask

  task automatic do_reset();
    ereset = 1'b1;
    cycles(3);
    ereset = 1'b0;
    cycles(2);
  endtask

  // One 24-tick period; d >= 0: phi2 rises d ticks after phi0, d < 0: phi0 lags by -d.
  task automatic run_period(input int d, input int btn_at);
    for (int k = 0; k < 24; k++) begin
      if (d >= 0) begin
        phi0 = (k < 12);
        phi2 = (k >= d) && (k < d + 12);
      end else begin
        phi2 = (k < 12);
        phi0 = (k >= -d) && (k < -d + 12);
      end
      if (k == btn_at) btn_inc = 1'b1;
      @(negedge eclk);
    end
  endtask

  // Plant model when track=1: phase = tap - 40, one tick per tap step.
  task automatic run_stream(input int n, input int d, input bit track);
    for (int i = 0; i < n; i++) run_period(track ? int'(tap) - 40 : d, -1);
  endtask

  task automatic press(input bit up);
    if (up) btn_inc = 1'b1; else btn_dec = 1'b1;
    cycles(2);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cycles(2);
  endtask

  initial begin
    ereset = 1'b1; phi0 = 1'b1; phi2 = 1'b1;
    enable = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cycles(3);
    ereset = 1'b0;
    cycles(5);
    check("rst_no_valid", 32'(dv_count), 32'd0);
    check("rst_tap", 32'(tap), 32'd50);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_avg", 32'(avg), 32'd0);
    check("rst_at_limit", 32'(at_limit), 32'd0);
    phi0 = 1'b0; phi2 = 1'b0;
    cycles(2);

    // Single measurements
    dv_snap = dv_count;
    phi0 = 1'b1; cycles(5); phi2 = 1'b1; cycles(6);
    check("diff_plus5", 32'(diff), 32'h0005);
    check("diff_one_pulse", 32'(dv_count - dv_snap), 32'd1);
    phi0 = 1'b0; phi2 = 1'b0; cycles(3);
    phi2 = 1'b1; cycles(7); phi0 = 1'b1; cycles(6);
    check("diff_minus7", 32'(diff), 32'hFFF9);
    phi0 = 1'b0; phi2 = 1'b0; cycles(3);
    dv_snap = dv_count;
    phi0 = 1'b1; phi2 = 1'b1; cycles(6);
    check("diff_same_cycle", 32'(diff), 32'h0000);
    check("diff_same_pulse", 32'(dv_count - dv_snap), 32'd1);
    phi0 = 1'b0; phi2 = 1'b0; cycles(3);

    // Manual buttons
    btn_inc = 1'b1; cycles(1000); btn_inc = 1'b0; cycles(3);
    check("btn_hold_once", 32'(tap), 32'd51);
    btn_inc = 1'b1; btn_dec = 1'b1; cycles(3);
    btn_inc = 1'b0; btn_dec = 1'b0; cycles(3);
    check("btn_both_cancel", 32'(tap), 32'd51);

    // Closed-loop convergence
    do_reset();
    enable = 1'b1;
    run_stream(10, 0, 1'b1);
    check("track_first_avg", 32'(avg), 32'h000A);
    check("track_first_step", 32'(tap), 32'd49);
    run_stream(70, 0, 1'b1);
    check("track_converged_tap", 32'(tap), 32'd42);
    check("track_not_locked", 32'(locked), 32'd0);
    run_stream(26, 0, 1'b1);
    check("track_3_inband", 32'(locked), 32'd0);
    check("track_inband_avg", 32'(avg), 32'h0002);
    run_stream(8, 0, 1'b1);
    check("track_locked", 32'(locked), 32'd1);
    check("track_hold_tap", 32'(tap), 32'd42);

    // Manual step in the same cycle as an auto request
    do_reset();
    enable = 1'b1;
    run_stream(9, 10, 1'b0);
    run_period(10, 12);
    btn_inc = 1'b0;
    cycles(3);
    check("manual_wins_avg", 32'(avg), 32'h000A);
    check("manual_wins_tap", 32'(tap), 32'd51);
    phi0 = 1'b0; phi2 = 1'b0;

    // Timeout discards partial accumulation
    do_reset();
    enable = 1'b0;
    run_stream(5, 11, 1'b0);
    dv_snap = dv_count;
    phi0 = 1'b1;
    cycles(4200);
    check("timeout_no_sample", 32'(dv_count - dv_snap), 32'd0);
    phi0 = 1'b0;
    cycles(3);
    run_stream(8, 4, 1'b0);
    check("timeout_acc_cleared", 32'(avg), 32'h0004);

    // Lower limit
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) press(1'b0);
    check("min_reached", 32'(tap), 32'd0);
    enable = 1'b1;
    run_stream(10, 10, 1'b0);
    check("min_hold", 32'(tap), 32'd0);
    check("min_at_limit", 32'(at_limit), 32'd1);

    // Upper limit
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 449; i++) press(1'b1);
    check("max_reached", 32'(tap), 32'd499);
    check("max_no_limit_yet", 32'(at_limit), 32'd0);
    enable = 1'b1;
    run_stream(10, -10, 1'b0);
    check("max_avg", 32'(avg), 32'hFFF6);
    check("max_hold", 32'(tap), 32'd499);
    check("max_at_limit", 32'(at_limit), 32'd1);

    // Asynchronous reset in the middle of WAIT2
    phi0 = 1'b1;
    cycles(3);
    #2 ereset = 1'b1;
    #1;
    check("arst_tap", 32'(tap), 32'd50);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_valid", 32'(diff_valid), 32'd0);
    check("arst_avg", 32'(avg), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_at_limit", 32'(at_limit), 32'd0);
    @(negedge eclk);
    ereset = 1'b0;
    dv_snap = dv_count;
    cycles(5);
    check("arst_no_spurious", 32'(dv_count - dv_snap), 32'd0);
    phi0 = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
